reg_pipe: RTL and testbench
===========================

# reg_pipe

Parametrised register pipeline with valid/ready flow control, bubble collapsing, a synchronous clear and configurable output width extension. It replaces single-stage, reset-muxed output registers wherever a datapath needs a registered slice of configurable depth that can absorb back-pressure. Typical placements are timing-closure slices on long buses and retiming between producer and consumer blocks.

## Interface
Parameters:
- WIDTH, 8: payload width in bits, ≥1.
- DEPTH, 2: number of register stages, ≥1.
- OUT_WIDTH, 8: width of out_data, ≥1.
- SIGN_EXT, 0: 1 sign-extends, 0 zero-extends, when OUT_WIDTH > WIDTH.
- RESET_VALUE, 0: WIDTH-bit value loaded into every stage's data register on reset or clear.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-high: asserting it clears state immediately; state is held while it is high.
- clr  in  1  synchronous clear; empties the pipeline at the next edge.
- in_valid  in  1  input payload valid.
- in_ready  out  1  pipeline accepts input this cycle.
- in_data  in  WIDTH  input payload.
- out_valid  out  1  output payload valid.
- out_ready  in  1  consumer accepts output this cycle.
- out_data  out  OUT_WIDTH  extended or truncated payload of the last stage.

## Operation
- State per stage i (0..DEPTH-1): valid bit v[i] and data register d[i]. Stage DEPTH-1 is the output stage.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1].
  - in_ready = r[0].
- Per-edge update for stage i. The source is in_valid/in_data for i=0, otherwise v[i-1]/d[i-1].
  - If r[i]: v[i] <= source valid.
  - If r[i] & source valid: d[i] <= source data.
  - Otherwise v[i] and d[i] hold.
- Effect of the ready chain:
  - Bubbles collapse: a stalled output stage still lets upstream stages advance into empty slots.
  - Capacity is exactly DEPTH entries.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out_valid = v[DEPTH-1].
- Priority:
  - rst (async) first, then clr, then normal update.
  - rst and clr both force every v[i]=0 and every d[i]=RESET_VALUE.
  - An input offered in the same cycle as clr is dropped even though in_ready may be high.
- Width rule for out_data (from d[DEPTH-1]):
  - OUT_WIDTH > WIDTH: upper bits are copies of d[DEPTH-1][WIDTH-1] if SIGN_EXT=1, else 0.
  - OUT_WIDTH = WIDTH: passed through unchanged.
  - OUT_WIDTH < WIDTH: the low OUT_WIDTH bits are output.
- out_data is driven continuously, including when out_valid=0. After reset or clear it shows the extended RESET_VALUE.
- Payload order is strictly preserved. No entry is duplicated or lost except through clr or rst.

## Timing
- Reset values:
  - in_ready=1 (while rst is high, in_ready follows out_ready | empty = 1).
  - out_valid=0.
  - out_data = extended RESET_VALUE.
- Latency: an item accepted at edge N into an empty pipeline appears with out_valid=1 after edge N+DEPTH-1. That is, DEPTH cycles from input sample to output register.
- Throughput: one item per cycle sustained while out_ready=1.
- Full pipeline (all v=1) with out_ready=0: in_ready=0; all state held.
- Full pipeline with out_ready=1: in_ready=1 in the same cycle (combinational path out_ready→in_ready); simultaneous input and output transfer.
- clr or rst mid-stream: all in-flight items are discarded. in_ready is 1 in the cycle after clr.
- rst deassertion: the first edge after release performs a normal update.

## Test plan
- Reset and width rule:
  - Setup: WIDTH=2, OUT_WIDTH=5, SIGN_EXT=1, RESET_VALUE=2'b10.
  - Check during and after rst: out_valid=0, out_data=5'b11110, in_ready=1.
  - With SIGN_EXT=0: out_data=5'b00010.
- Streaming:
  - Setup: DEPTH=3, out_ready=1.
  - Stimulus: feed 1,2,3,0 on consecutive cycles.
  - Required response: out_valid first rises 3 cycles after the first accept; outputs 1,2,3,0 (zero/sign-extended) on consecutive cycles with no gaps.
- Back-pressure and bubble collapse:
  - Setup: DEPTH=3, out_ready=0.
  - Stimulus: offer items every cycle, with an in_valid=0 bubble after the first.
  - Required response: exactly 3 items are accepted, then in_ready=0.
  - Then raise out_ready: the items drain in order, one per cycle, with no duplicates.
- Full plus simultaneous transfer:
  - Stimulus: with the pipeline full, assert out_ready=1 and in_valid=1 in the same cycle.
  - Required response: in_ready=1, one item leaves, one enters; occupancy stays 3.
- Synchronous clear:
  - Stimulus: assert clr for one cycle with 2 items in flight and in_valid=1.
  - Required response: next cycle out_valid=0 and out_data=extended RESET_VALUE. The offered input and both in-flight items never appear at the output.
- Asynchronous reset mid-stall:
  - Stimulus: pulse rst between clock edges while full and stalled.
  - Required response: out_valid falls without waiting for a clock edge. After release, the next accepted item emerges after DEPTH cycles.

Source files
------------

// File: rtl/reg_pipe_if.sv
// Valid/ready handshake bundle for reg_pipe: upstream (in_*) and downstream (out_*) sides.
// The pipeline takes the slave view; the environment that feeds and drains it takes master.
interface reg_pipe_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned OUT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/reg_pipe.sv
// Register pipeline of DEPTH valid/ready stages with bubble collapsing and synchronous clear.
// out_data is the last stage's payload, zero/sign-extended or truncated to OUT_WIDTH.
module reg_pipe #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      DEPTH       = 2,
   parameter int unsigned      OUT_WIDTH   = 8,
   parameter bit               SIGN_EXT    = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input logic       clk,
   input logic       rst,
   input logic       clr,
   reg_pipe_if.slave pipe
);

   logic [DEPTH-1:0] v_q, v_d;
   logic [DEPTH-1:0] rdy;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];

   // A stage can load when it is empty or everything downstream of it is moving.
   always_comb begin
      logic acc;
      acc = pipe.out_ready;
      rdy = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         acc    = ~v_q[i] | acc;
         rdy[i] = acc;
      end
   end

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (clr) begin
         v_d = '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_d[i] = RESET_VALUE;
         end
      end else begin
         if (rdy[0]) begin
            v_d[0] = pipe.in_valid;
         end
         if (rdy[0] && pipe.in_valid) begin
            d_d[0] = pipe.in_data;
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (rdy[i]) begin
               v_d[i] = v_q[i-1];
            end
            if (rdy[i] && v_q[i-1]) begin
               d_d[i] = d_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_q[i] <= RESET_VALUE;
         end
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign pipe.in_ready  = rdy[0];
   assign pipe.out_valid = v_q[DEPTH-1];

   if (OUT_WIDTH > WIDTH) begin : g_extend
      logic fill;
      assign fill          = SIGN_EXT ? d_q[DEPTH-1][WIDTH-1] : 1'b0;
      assign pipe.out_data = {{(OUT_WIDTH - WIDTH){fill}}, d_q[DEPTH-1]};
   end else if (OUT_WIDTH == WIDTH) begin : g_pass
      assign pipe.out_data = d_q[DEPTH-1];
   end else begin : g_trunc
      assign pipe.out_data = d_q[DEPTH-1][OUT_WIDTH-1:0];
   end

endmodule

// File: tb/tb_reg_pipe.sv
// Directed plus random bench for reg_pipe: three instances (sign-extend, zero-extend,
// truncate) share one stimulus and are compared against an occupancy/age queue model.
module tb_reg_pipe;
   localparam int unsigned     DEPTH  = 3;
   localparam logic [1:0]      RST_V  = 2'b10;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       in_valid;
   logic [1:0] in_data;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   reg_pipe_if #(.WIDTH(2), .OUT_WIDTH(5)) if_a ();
   reg_pipe_if #(.WIDTH(2), .OUT_WIDTH(5)) if_b ();
   reg_pipe_if #(.WIDTH(2), .OUT_WIDTH(1)) if_c ();

   assign if_a.in_valid  = in_valid;
   assign if_a.in_data   = in_data;
   assign if_a.out_ready = out_ready;
   assign if_b.in_valid  = in_valid;
   assign if_b.in_data   = in_data;
   assign if_b.out_ready = out_ready;
   assign if_c.in_valid  = in_valid;
   assign if_c.in_data   = in_data;
   assign if_c.out_ready = out_ready;

   reg_pipe #(.WIDTH(2), .DEPTH(DEPTH), .OUT_WIDTH(5), .SIGN_EXT(1'b1), .RESET_VALUE(RST_V))
      u_sx (.clk(clk), .rst(rst), .clr(clr), .pipe(if_a));
   reg_pipe #(.WIDTH(2), .DEPTH(DEPTH), .OUT_WIDTH(5), .SIGN_EXT(1'b0), .RESET_VALUE(RST_V))
      u_zx (.clk(clk), .rst(rst), .clr(clr), .pipe(if_b));
   reg_pipe #(.WIDTH(2), .DEPTH(DEPTH), .OUT_WIDTH(1), .SIGN_EXT(1'b1), .RESET_VALUE(RST_V))
      u_tr (.clk(clk), .rst(rst), .clr(clr), .pipe(if_c));

   always #5 clk = ~clk;

   // Model: FIFO of payloads with edges-since-accept; an entry k places from the head can
   // sit no further than stage DEPTH-1-k, so the head is visible once it is DEPTH-1 edges old.
   logic [1:0] q_data[$];
   int         q_age[$];
   logic [1:0] last_v;

   function automatic bit exp_valid();
      return (q_data.size() > 0) && (q_age[0] >= int'(DEPTH) - 1);
   endfunction

   function automatic bit exp_ready();
      return (q_data.size() < int'(DEPTH)) || out_ready;
   endfunction

   function automatic logic [1:0] exp_payload();
      return exp_valid() ? q_data[0] : last_v;
   endfunction

   task automatic model_clear();
      q_data.delete();
      q_age.delete();
      last_v = RST_V;
   endtask

   task automatic model_edge();
      bit of, inf;
      if (rst || clr) begin
         model_clear();
      end else begin
         of  = exp_valid() && out_ready;
         inf = in_valid && exp_ready();
         if (of) begin
            last_v = q_data.pop_front();
            void'(q_age.pop_front());
         end
         foreach (q_age[i]) q_age[i]++;
         if (inf) begin
            q_data.push_back(in_data);
            q_age.push_back(0);
         end
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [1:0] p;
      p = exp_payload();
      check({tag, "/in_ready"},  8'(if_a.in_ready),  8'(exp_ready()));
      check({tag, "/out_valid"}, 8'(if_a.out_valid), 8'(exp_valid()));
      check({tag, "/sx_data"},   8'(if_a.out_data),  8'({{3{p[1]}}, p}));
      check({tag, "/zx_in_rdy"}, 8'(if_b.in_ready),  8'(exp_ready()));
      check({tag, "/zx_valid"},  8'(if_b.out_valid), 8'(exp_valid()));
      check({tag, "/zx_data"},   8'(if_b.out_data),  8'({3'b000, p}));
      check({tag, "/tr_valid"},  8'(if_c.out_valid), 8'(exp_valid()));
      check({tag, "/tr_data"},   8'(if_c.out_data),  8'(p[0]));
   endtask

   // Inputs are set just after an edge; outputs are checked mid-cycle, then the edge is taken.
   task automatic step(input string tag);
      #2;
      check_all(tag);
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] svals [4];
      svals = '{2'd1, 2'd2, 2'd3, 2'd0};
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      model_clear();
      #1;
      check("rst/sx_lit", 8'(if_a.out_data), 8'b0001_1110);
      check("rst/zx_lit", 8'(if_b.out_data), 8'b0000_0010);
      step("rst0");
      in_valid = 1'b1; in_data = 2'd3;
      step("rst1");
      rst = 1'b0; in_valid = 1'b0;
      step("post_rst");

      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = svals[i];
         step("stream");
      end
      in_valid = 1'b0;
      repeat (5) step("stream_drain");

      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = (i != 1);
         in_data  = 2'($urandom);
         step("backpressure");
      end
      out_ready = 1'b1; in_valid = 1'b1; in_data = 2'($urandom);
      step("full_xfer");
      out_ready = 1'b0; in_data = 2'($urandom);
      step("full_hold");
      out_ready = 1'b1; in_valid = 1'b0;
      repeat (5) step("drain");

      out_ready = 1'b0; in_valid = 1'b1;
      repeat (2) begin
         in_data = 2'($urandom);
         step("clr_fill");
      end
      clr = 1'b1; in_data = 2'($urandom);
      step("clr");
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) step("after_clr");

      repeat (300) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         clr       = ($urandom_range(0, 24) == 0);
         step("random");
      end
      clr = 1'b0;

      out_ready = 1'b0; in_valid = 1'b1;
      repeat (4) begin
         in_data = 2'($urandom);
         step("stall_fill");
      end
      #2;
      check_all("full_stall");
      rst = 1'b1;
      #1;
      model_clear();
      check_all("async_rst");
      @(posedge clk);
      #1;
      step("rst_held");
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 2'($urandom);
      step("post_rst_in");
      in_valid = 1'b0;
      repeat (4) step("post_rst_lat");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
